// File: rtl/mips_mem_pkg.sv
// Shared memory-subsystem definitions used by the instruction memory and the fetch stage.
//   im_state_e : instruction-memory life cycle (clear array, accept boot words, serve core)
//   UNDEFINE   : value driven on data outputs when nothing valid is presented
//   IM_ADDR_W  : core instruction address width (word addressed)
//   IM_DATA_W  : instruction word width
package mips_mem_pkg;

    localparam int          IM_ADDR_W = 11;
    localparam int          IM_DATA_W = 32;
    localparam logic [31:0] UNDEFINE  = 32'b0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } im_state_e;

endpackage

// File: rtl/im_sram_array.sv
// Single-port synchronous storage with a registered read port.
// Ports:
//   clk      in   clock
//   rst_n    in   async active-low reset (read register only; storage is never reset)
//   we       in   write strobe
//   re       in   read strobe
//   addr     in   ADDR_W word address shared by read and write
//   wdata    in   DATA_W write data
//   rdata_q  out  DATA_W registered read data, holds when re=0
// Addresses at or above DEPTH are decoded here: writes are dropped and reads return zero.
module im_sram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_q
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // Extra top bit keeps the compare exact even when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory responder for the fetch stage, with a boot-loader fill port.
// After reset the array is zeroed (CLEAR, skipped when CLEAR_EN=0), then boot words are
// accepted from the loader stream (LOAD), then the core port is served (RUN) until reset.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   im_cen/im_wen/im_oen    core chip/write/output enables, all active low
//   im_addr, im_datain      core word address and write data
//   im_dataout              core read data (gated to zero while im_oen is high)
//   ld_valid/ld_data/ld_last boot word stream in; ld_ready out
//   mem_ready               high only once the core port is live
module instruction_memory
    import mips_mem_pkg::*;
#(
    parameter int DATA_W   = IM_DATA_W,
    parameter int ADDR_W   = IM_ADDR_W,
    parameter int DEPTH    = 2048,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              im_cen,
    input  logic              im_wen,
    input  logic              im_oen,
    input  logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_datain,
    output logic [DATA_W-1:0] im_dataout,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              mem_ready
);

    localparam im_state_e         START_ST = CLEAR_EN ? ST_CLEAR : ST_LOAD;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    im_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ld_ready_q;
    logic              mem_ready_q;
    logic              ld_xfer;

    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata_q;

    assign ld_xfer = (state_q == ST_LOAD) && ld_valid && ld_ready_q;

    // Sequencer; ld_ready/mem_ready are registered alongside the state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= START_ST;
            ptr_q       <= '0;
            ld_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == LAST_PTR) begin
                        ptr_q      <= '0;
                        state_q    <= ST_LOAD;
                        ld_ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + PTR_ONE;
                    end
                end
                ST_LOAD: begin
                    ld_ready_q <= 1'b1;
                    if (ld_xfer) begin
                        // Full array ends the load without wrapping onto word 0.
                        if (ld_last || (ptr_q == LAST_PTR)) begin
                            ptr_q       <= '0;
                            state_q     <= ST_RUN;
                            ld_ready_q  <= 1'b0;
                            mem_ready_q <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + PTR_ONE;
                        end
                    end
                end
                ST_RUN: begin
                    ld_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= START_ST;
                    ptr_q       <= '0;
                    ld_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Single array port: clear and load own it before RUN, the core owns it after,
    // so there is never more than one access per cycle. Reads only happen in RUN,
    // which keeps the read register at its reset value of zero until then.
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = ptr_q;
        arr_wdata = DATA_W'(UNDEFINE);
        case (state_q)
            ST_CLEAR: begin
                arr_we = 1'b1;
            end
            ST_LOAD: begin
                arr_we    = ld_xfer;
                arr_wdata = ld_data;
            end
            ST_RUN: begin
                arr_addr  = im_addr;
                arr_wdata = im_datain;
                arr_we    = !im_cen && !im_wen;
                arr_re    = !im_cen && im_wen;
            end
            default: begin
                arr_we = 1'b0;
            end
        endcase
    end

    im_sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (arr_we),
        .re      (arr_re),
        .addr    (arr_addr),
        .wdata   (arr_wdata),
        .rdata_q (arr_rdata_q)
    );

    assign im_dataout = im_oen ? DATA_W'(UNDEFINE) : arr_rdata_q;
    assign ld_ready   = ld_ready_q;
    assign mem_ready  = mem_ready_q;

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen, wen, oen;
    logic [AW-1:0] addr;
    logic [DW-1:0] datain;
    logic          ld_valid, ld_last;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] dout, dout0;
    logic          ld_ready, ld_ready0, mem_ready, mem_ready0;

    instruction_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLEAR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .im_cen(cen), .im_wen(wen), .im_oen(oen),
        .im_addr(addr), .im_datain(datain), .im_dataout(dout),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .mem_ready(mem_ready)
    );

    instruction_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLEAR_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .im_cen(cen), .im_wen(wen), .im_oen(oen),
        .im_addr(addr), .im_datain(datain), .im_dataout(dout0),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready0), .mem_ready(mem_ready0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: array contents, current read register, next loader slot.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_rd;
    int            ld_ptr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cen = 1'b1; wen = 1'b1; oen = 1'b0; addr = '0; datain = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    endtask

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rd = '0;
        ld_ptr   = 0;
    endtask

    task automatic wait_ld_ready(input int max_cycles, output int cycles);
        cycles = 0;
        while (ld_ready !== 1'b1 && cycles < max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    task automatic load_word(input logic [DW-1:0] w, input logic last);
        n_checks++;
        if (ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready_before_word%0d: ld_ready=%b expected 1", ld_ptr, ld_ready);
        end
        ld_valid = 1'b1; ld_data = w; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        model_mem[ld_ptr] = w;
        ld_ptr++;
    endtask

    task automatic core_read(input logic [AW-1:0] a);
        cen = 1'b0; wen = 1'b1; addr = a;
        tick();
        cen = 1'b1;
        model_rd = (int'(a) < DEPTH) ? model_mem[a] : '0;
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cen = 1'b0; wen = 1'b0; addr = a; datain = d;
        tick();
        cen = 1'b1; wen = 1'b1;
        if (int'(a) < DEPTH) model_mem[a] = d;
    endtask

    task automatic test_reset;
        int rise, bad;
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (ld_ready !== 1'b0 || mem_ready !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ld_ready=%b mem_ready=%b dout=%h expected 0 0 0", ld_ready, mem_ready, dout);
        end
        rst_n = 1'b1;
        model_clear();
        rise = -1; bad = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (ld_ready === 1'b1 && rise < 0) rise = c;
            if (mem_ready !== 1'b0 || dout !== '0) bad++;
        end
        $display("reset: ld_ready rose after %0d cycles", rise);
        n_checks++;
        if (rise != DEPTH) begin
            n_fail++;
            $display("FAIL clear_duration: ld_ready rose at cycle %0d expected %0d", rise, DEPTH);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_outputs: %0d cycles with mem_ready/dout nonzero expected 0", bad);
        end
    endtask

    task automatic test_load_last;
        logic [DW-1:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            load_word(words[i], i == 2);
            $display("load: word %0d = %h last=%0d mem_ready=%b", i, words[i], i == 2, mem_ready);
            n_checks++;
            if (mem_ready !== (i == 2)) begin
                n_fail++;
                $display("FAIL load_mem_ready_%0d: mem_ready=%b expected %b", i, mem_ready, i == 2);
            end
        end
        n_checks++;
        if (ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ld_ready_drop: ld_ready=%b expected 0", ld_ready);
        end
        for (int a = 0; a < 4; a++) begin
            cen = 1'b0; wen = 1'b1; addr = AW'(a);
            #1;
            n_checks++;
            if (dout !== model_rd) begin
                n_fail++;
                $display("FAIL read_latency_%0d: dout=%h before edge expected %h", a, dout, model_rd);
            end
            core_read(AW'(a));
            $display("read: addr %0d -> %h", a, dout);
            n_checks++;
            if (dout !== model_rd) begin
                n_fail++;
                $display("FAIL read_loaded_%0d: dout=%h expected %h", a, dout, model_rd);
            end
        end
    endtask

    task automatic test_write_read_oen;
        logic [DW-1:0] held;
        held = model_rd;
        core_write(AW'(5), 32'hDEADBEEF);
        $display("write: addr 5 <- deadbeef, dout=%h", dout);
        n_checks++;
        if (dout !== held) begin
            n_fail++;
            $display("FAIL write_holds_rd: dout=%h expected %h", dout, held);
        end
        oen = 1'b1;
        core_read(AW'(5));
        n_checks++;
        if (dout !== '0) begin
            n_fail++;
            $display("FAIL oen_gate: dout=%h expected 0", dout);
        end
        oen = 1'b0;
        #1;
        $display("read: addr 5 oen 1->0 -> %h", dout);
        n_checks++;
        if (dout !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL oen_release: dout=%h expected deadbeef", dout);
        end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] w4;
        w4 = $urandom() | 32'h1;
        core_write(AW'(4), w4);
        core_read(AW'(20));
        $display("read: addr 20 -> %h", dout);
        n_checks++;
        if (dout !== '0) begin
            n_fail++;
            $display("FAIL oor_read: dout=%h expected 0", dout);
        end
        core_write(AW'(20), ~w4);
        core_read(AW'(4));
        $display("read: addr 4 after oor write -> %h", dout);
        n_checks++;
        if (dout !== model_mem[4]) begin
            n_fail++;
            $display("FAIL oor_write_dropped: dout=%h expected %h", dout, model_mem[4]);
        end
    endtask

    task automatic test_random_rw;
        int errs;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int op;
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            a   = AW'($urandom_range(0, DEPTH + 7));
            d   = $urandom();
            op  = $urandom_range(0, 2);
            oen = $urandom_range(0, 3) == 0;
            addr = a; datain = d;
            cen = (op == 2); wen = (op != 0);
            tick();
            if (op == 0 && int'(a) < DEPTH) model_mem[a] = d;
            if (op == 1) model_rd = (int'(a) < DEPTH) ? model_mem[a] : '0;
            n_checks++;
            if (dout !== (oen ? '0 : model_rd)) begin
                n_fail++;
                errs++;
                $display("FAIL random_rw_%0d: op=%0d addr=%0d oen=%b dout=%h expected %h", i, op, a, oen, dout, oen ? '0 : model_rd);
            end
        end
        cen = 1'b1; wen = 1'b1; oen = 1'b0;
        $display("random: 200 core ops, %0d errors", errs);
    endtask

    task automatic test_full_load;
        int cyc;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        wait_ld_ready(40, cyc);
        n_checks++;
        if (cyc != DEPTH) begin
            n_fail++;
            $display("FAIL full_clear_wait: %0d cycles expected %0d", cyc, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            load_word($urandom() | 32'h1, 1'b0);
            if (i == DEPTH - 2) begin
                n_checks++;
                if (mem_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early_run: mem_ready=%b expected 0", mem_ready);
                end
            end
        end
        $display("load: %0d words without last, mem_ready=%b ld_ready=%b", DEPTH, mem_ready, ld_ready);
        n_checks++;
        if (mem_ready !== 1'b1 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_to_run: mem_ready=%b ld_ready=%b expected 1 0", mem_ready, ld_ready);
        end
        ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        n_checks++;
        if (ld_ready !== 1'b0 || mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL extra_word_state: ld_ready=%b mem_ready=%b expected 0 1", ld_ready, mem_ready);
        end
        core_read(AW'(0));
        $display("read: addr 0 after extra word -> %h", dout);
        n_checks++;
        if (dout !== model_mem[0]) begin
            n_fail++;
            $display("FAIL extra_word_no_wrap: dout=%h expected %h", dout, model_mem[0]);
        end
        core_read(AW'(DEPTH - 1));
        n_checks++;
        if (dout !== model_mem[DEPTH-1]) begin
            n_fail++;
            $display("FAIL full_last_word: dout=%h expected %h", dout, model_mem[DEPTH-1]);
        end
    endtask

    task automatic test_reset_mid_load;
        int cyc;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        wait_ld_ready(40, cyc);
        n_checks++;
        if (cyc != DEPTH) begin
            n_fail++;
            $display("FAIL midload_clear_wait: %0d cycles expected %0d", cyc, DEPTH);
        end
        load_word($urandom() | 32'h1, 1'b0);
        load_word($urandom() | 32'h1, 1'b0);
        rst_n = 1'b0;
        #1;
        $display("reset mid-load: ld_ready=%b mem_ready=%b dout=%h", ld_ready, mem_ready, dout);
        n_checks++;
        if (ld_ready !== 1'b0 || mem_ready !== 1'b0 || dout !== '0 || ld_ready0 !== 1'b0 || mem_ready0 !== 1'b0 || dout0 !== '0) begin
            n_fail++;
            $display("FAIL async_reset: ld_ready=%b mem_ready=%b dout=%h ld_ready0=%b mem_ready0=%b dout0=%h expected all 0",
                     ld_ready, mem_ready, dout, ld_ready0, mem_ready0, dout0);
        end
        tick();
        rst_n = 1'b1;
        model_clear();
        tick();
        n_checks++;
        if (ld_ready0 !== 1'b1 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL first_cycle_ready: ld_ready0=%b ld_ready=%b expected 1 0", ld_ready0, ld_ready);
        end
        wait_ld_ready(40, cyc);
        n_checks++;
        if (cyc + 1 != DEPTH) begin
            n_fail++;
            $display("FAIL clear_restart: %0d cycles expected %0d", cyc + 1, DEPTH);
        end
        load_word($urandom() | 32'h1, 1'b1);
        core_read(AW'(1));
        $display("read: addr 1 after reload -> %h", dout);
        n_checks++;
        if (dout !== model_mem[1]) begin
            n_fail++;
            $display("FAIL clear_rezeroed: dout=%h expected %h", dout, model_mem[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_load_last();
        test_write_read_oen();
        test_out_of_range();
        test_random_rw();
        test_full_load();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
